fb_page_arbiter: RTL and testbench

- Controller for a double-buffered (ping-pong) frame buffer RAM with one synchronous port, sitting between the PPU pixel stream and vga_out.
- Sequences PPU pixels into raster addresses on the back page and serves VGA reads from the display page; VGA reads always win the port.
- Swaps pages only at vblank, after a complete frame has been written and drained, so the display never tears.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_wr_fifo.sv | 52 +++++
 rtl/fb_page_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fb_page_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and geometry for the ping-pong frame buffer arbiter
package fb_pkg;

  localparam int FB_W       = 256;
  localparam int FB_H       = 240;
  localparam int PIX_W      = 6;
  localparam int FIFO_DEPTH = 4;

  typedef logic [15:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t         addr;
    logic [PIX_W-1:0] pix;
  } fb_entry_t;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  // Raster address within one page: line in the high byte, column in the low byte.
  function automatic fb_addr_t raster_addr(input logic [7:0] y, input logic [7:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - small synchronous FIFO buffering pixel writes while VGA owns the port
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fb_entry_t              wr_entry,
  input  logic                   pop,
  output fb_entry_t              rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_page_arbiter.sv
// rtl/fb_page_arbiter.sv - single-port frame buffer arbiter: PPU writes to the back page,
// VGA reads from the display page with priority, page swap only at vblank after a full drain.
module fb_page_arbiter #(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H,
  parameter int PIX_W      = fb_pkg::PIX_W,
  parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  input  logic             ppu_valid,
  output logic             ppu_ready,
  input  logic [PIX_W-1:0] ppu_pix,
  input  logic             ppu_sof,
  input  logic             vga_rd_req,
  input  logic [7:0]       vga_x,
  input  logic [7:0]       vga_y,
  input  logic             vga_vblank,
  output logic [PIX_W-1:0] vga_rd_data,
  output logic             vga_rd_valid,
  output logic [16:0]      mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             disp_page,
  output logic             frame_done,
  output logic [7:0]       abort_cnt
);

  import fb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic [7:0]      wr_x;
  logic [7:0]      wr_y;
  logic            accept;
  logic            last_pix;
  logic            push;
  logic            pop;
  fb_entry_t       push_entry;
  fb_entry_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            rd_issue;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (pix_clk),
    .rst_n    (rst_n),
    .push     (push),
    .wr_entry (push_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    case (state)
      IDLE:    ppu_ready = 1'b1;
      FILL:    ppu_ready = ~fifo_full;
      default: ppu_ready = 1'b0;
    endcase
  end

  assign accept   = ppu_valid & ppu_ready;
  assign last_pix = (wr_x == 8'(FB_W-1)) && (wr_y == 8'(FB_H-1));

  // A sof pixel always lands at (0,0); pixels seen in IDLE without sof are dropped.
  always_comb begin
    push            = 1'b0;
    push_entry.addr = raster_addr(wr_y, wr_x);
    push_entry.pix  = ppu_pix;
    if (accept) begin
      if (ppu_sof) begin
        push            = (state == IDLE) || (state == FILL);
        push_entry.addr = '0;
      end else begin
        push = (state == FILL);
      end
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_x       <= '0;
      wr_y       <= '0;
      disp_page  <= 1'b0;
      abort_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && ppu_sof) begin
            wr_x  <= 8'd1;
            wr_y  <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (ppu_sof) begin
              wr_x <= 8'd1;
              wr_y <= '0;
              if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 1'b1;
            end else if (last_pix) begin
              wr_x  <= '0;
              wr_y  <= '0;
              state <= DRAIN;
            end else if (wr_x == 8'(FB_W-1)) begin
              wr_x <= '0;
              wr_y <= wr_y + 1'b1;
            end else begin
              wr_x <= wr_x + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Empty FIFO means every write of this frame is already on the back page.
          if (fifo_count == '0 && vga_vblank) begin
            disp_page  <= ~disp_page;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = ~vga_rd_req & ~fifo_empty;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      rd_issue     <= 1'b0;
      vga_rd_valid <= 1'b0;
    end else begin
      rd_issue     <= vga_rd_req;
      vga_rd_valid <= rd_issue;
      if (vga_rd_req) begin
        mem_addr <= {disp_page, vga_y, vga_x};
        mem_we   <= 1'b0;
      end else if (!fifo_empty) begin
        mem_addr  <= {~disp_page, head.addr};
        mem_we    <= 1'b1;
        mem_wdata <= head.pix;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

  assign vga_rd_data = mem_rdata;

endmodule

// File: tb/tb_fb_page_arbiter.sv
// tb/tb_fb_page_arbiter.sv - directed bench for fb_page_arbiter
module tb_fb_page_arbiter;

  logic        pix_clk = 1'b0;
  logic        rst_n;
  logic        ppu_valid;
  logic        ppu_ready;
  logic [5:0]  ppu_pix;
  logic        ppu_sof;
  logic        vga_rd_req;
  logic [7:0]  vga_x;
  logic [7:0]  vga_y;
  logic        vga_vblank;
  logic [5:0]  vga_rd_data;
  logic        vga_rd_valid;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata = '0;
  logic        disp_page;
  logic        frame_done;
  logic [7:0]  abort_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          frame_done_cnt = 0;
  logic [22:0] exp_q[$];
  logic [22:0] exp_w;

  fb_page_arbiter dut (
    .pix_clk      (pix_clk),
    .rst_n        (rst_n),
    .ppu_valid    (ppu_valid),
    .ppu_ready    (ppu_ready),
    .ppu_pix      (ppu_pix),
    .ppu_sof      (ppu_sof),
    .vga_rd_req   (vga_rd_req),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_vblank   (vga_vblank),
    .vga_rd_data  (vga_rd_data),
    .vga_rd_valid (vga_rd_valid),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .disp_page    (disp_page),
    .frame_done   (frame_done),
    .abort_cnt    (abort_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic logic [5:0] ram_f(input logic [16:0] a);
    return a[5:0] ^ a[13:8] ^ {5'b0, a[16]};
  endfunction

  function automatic logic [5:0] pix_of(input int p);
    int x;
    int y;
    x = p % 256;
    y = p / 256;
    return 6'((x + y) % 64);
  endfunction

  // RAM stand-in with one cycle of read latency
  always @(posedge pix_clk) mem_rdata <= ram_f(mem_addr);

  // Every write must match the next pixel the bench handed over, in order
  always @(negedge pix_clk) begin
    if (rst_n) begin
      if (frame_done) frame_done_cnt++;
      if (mem_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_w) begin
            n_fail++;
            $display("FAIL write_order: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_wdata, exp_w[22:6], exp_w[5:0]);
          end
        end
      end
    end
  end

  task automatic send_pix(input int p, input logic sof, input logic page, input bit expect_wr);
    int n;
    n = 0;
    ppu_valid = 1'b1;
    ppu_pix   = pix_of(p);
    ppu_sof   = sof;
    while (!ppu_ready && n < 200) begin
      @(negedge pix_clk);
      n++;
    end
    n_checks++;
    if (!ppu_ready) begin
      n_fail++;
      $display("FAIL send_timeout: ppu_ready=%b after %0d cycles, expected 1", ppu_ready, n);
    end else if (expect_wr) begin
      exp_q.push_back({page, 16'(p), pix_of(p)});
    end
    @(negedge pix_clk);
    ppu_valid = 1'b0;
    ppu_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge pix_clk);
      n++;
    end
    @(negedge pix_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ppu_valid = 1'b0; ppu_pix = '0; ppu_sof = 1'b0;
    vga_rd_req = 1'b0; vga_x = '0; vga_y = '0; vga_vblank = 1'b1;
    repeat (3) @(negedge pix_clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, vga_rd_valid, frame_done, disp_page, abort_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h rv=%b fd=%b dp=%b ac=%0d, expected all 0",
               mem_we, mem_addr, mem_wdata, vga_rd_valid, frame_done, disp_page, abort_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pix_clk);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, vga_rd_valid, frame_done, disp_page, abort_cnt} !== 35'd0
          || ppu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_outputs: cycle %0d we=%b addr=%h dp=%b ready=%b, expected zeros and ready=1",
                 i, mem_we, mem_addr, disp_page, ppu_ready);
      end
    end
  endtask

  task automatic test_discard();
    for (int p = 5; p < 25; p++) send_pix(p, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge pix_clk);
    n_checks++;
    if (mem_we !== 1'b0 || ppu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL discard: got we=%b ready=%b, expected we=0 ready=1", mem_we, ppu_ready);
    end
  endtask

  task automatic test_starve(inout int p);
    int          acc;
    logic [16:0] ra [0:22];
    acc = 0;
    ppu_valid = 1'b0;
    wait_drain();
    for (int i = 0; i < 23; i++) begin
      if (i >= 1 && i <= 20) begin
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== ra[i-1]) begin
          n_fail++;
          $display("FAIL read_issue: cycle %0d got we=%b addr=%h, expected we=0 addr=%h",
                   i, mem_we, mem_addr, ra[i-1]);
        end
      end
      if (i >= 2 && i <= 21) begin
        n_checks++;
        if (vga_rd_valid !== 1'b1 || vga_rd_data !== ram_f(ra[i-2])) begin
          n_fail++;
          $display("FAIL read_data: cycle %0d got valid=%b data=%h, expected valid=1 data=%h",
                   i, vga_rd_valid, vga_rd_data, ram_f(ra[i-2]));
        end
      end
      if (i == 20) begin
        n_checks++;
        if (ppu_ready !== 1'b0 || acc != 4) begin
          n_fail++;
          $display("FAIL starve: got ready=%b accepted=%0d, expected ready=0 accepted=4", ppu_ready, acc);
        end
      end
      if (i == 22) begin
        n_checks++;
        if (vga_rd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL read_valid_drop: got %b, expected 0", vga_rd_valid);
        end
      end
      if (i < 20) begin
        vga_rd_req = 1'b1;
        vga_x      = 8'(10 + i);
        vga_y      = 8'd3;
        ra[i]      = {1'b0, 8'd3, 8'(10 + i)};
        ppu_valid  = 1'b1;
        ppu_pix    = pix_of(p);
        if (ppu_ready) begin
          exp_q.push_back({1'b1, 16'(p), pix_of(p)});
          p++;
          acc++;
        end
      end else begin
        vga_rd_req = 1'b0;
        ppu_valid  = 1'b0;
      end
      @(negedge pix_clk);
    end
  endtask

  task automatic test_frame();
    int p;
    vga_vblank = 1'b0;
    send_pix(0, 1'b1, 1'b1, 1'b1);
    for (int q = 1; q < 1000; q++) send_pix(q, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (abort_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_before: got %0d, expected 0", abort_cnt);
    end
    send_pix(0, 1'b1, 1'b1, 1'b1);
    @(negedge pix_clk);
    n_checks++;
    if (abort_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_cnt: got %0d, expected 1", abort_cnt);
    end
    for (int q = 1; q < 500; q++) send_pix(q, 1'b0, 1'b1, 1'b1);
    p = 500;
    test_starve(p);
    while (p < 61440) begin
      send_pix(p, 1'b0, 1'b1, 1'b1);
      p++;
    end
    n_checks++;
    if (ppu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_ready: got %b, expected 0", ppu_ready);
    end
    repeat (100) @(negedge pix_clk);
    n_checks++;
    if (frame_done_cnt != 0 || disp_page !== 1'b0 || ppu_ready !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL vblank_wait: got swaps=%0d dp=%b ready=%b pending=%0d, expected 0 0 0 0",
               frame_done_cnt, disp_page, ppu_ready, exp_q.size());
    end
    vga_vblank = 1'b1;
    @(negedge pix_clk);
    n_checks++;
    if (frame_done !== 1'b1 || disp_page !== 1'b1) begin
      n_fail++;
      $display("FAIL swap: got frame_done=%b dp=%b, expected 1 1", frame_done, disp_page);
    end
    @(negedge pix_clk);
    n_checks++;
    if (frame_done !== 1'b0 || ppu_ready !== 1'b1 || frame_done_cnt != 1) begin
      n_fail++;
      $display("FAIL after_swap: got frame_done=%b ready=%b pulses=%0d, expected 0 1 1",
               frame_done, ppu_ready, frame_done_cnt);
    end
    vga_vblank = 1'b0;
  endtask

  task automatic test_read_page1();
    vga_rd_req = 1'b1; vga_x = 8'd7; vga_y = 8'd9;
    @(negedge pix_clk);
    vga_rd_req = 1'b0;
    n_checks++;
    if (mem_addr !== {1'b1, 8'd9, 8'd7} || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL page1_read: got addr=%h we=%b, expected addr=%h we=0", mem_addr, mem_we, {1'b1, 8'd9, 8'd7});
    end
    @(negedge pix_clk);
    n_checks++;
    if (vga_rd_valid !== 1'b1 || vga_rd_data !== ram_f({1'b1, 8'd9, 8'd7})) begin
      n_fail++;
      $display("FAIL page1_data: got valid=%b data=%h, expected 1 %h",
               vga_rd_valid, vga_rd_data, ram_f({1'b1, 8'd9, 8'd7}));
    end
  endtask

  task automatic test_async_reset();
    send_pix(0, 1'b1, 1'b0, 1'b1);
    for (int q = 1; q < 10; q++) send_pix(q, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, vga_rd_valid, frame_done, disp_page, abort_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL async_reset: got we=%b addr=%h wdata=%h dp=%b ac=%0d, expected all 0",
               mem_we, mem_addr, mem_wdata, disp_page, abort_cnt);
    end
    exp_q.delete();
    @(negedge pix_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge pix_clk);
    n_checks++;
    if (ppu_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got ready=%b we=%b, expected 1 0", ppu_ready, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_discard();
    test_frame();
    test_read_page1();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
